// File: rtl/ifu_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding word fetches, holds the result for decode.
// Optional exception entry/return (exc_req, eret, epc) is compiled in with `define IFU_EXC_EN.
module ifu_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000
`ifdef IFU_EXC_EN
  , parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        addr_err,
  output logic [31:0] fetch_count
`ifdef IFU_EXC_EN
  , input  logic        exc_req,
  input  logic        eret,
  output logic [31:0] epc
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic        drop_q, drop_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic        addr_err_q, addr_err_d;

  logic        take_redirect;
  logic [31:0] target_pc;
  logic        misaligned;

`ifdef IFU_EXC_EN
  logic [31:0] epc_q, epc_d;
`endif

  // Pick the control-flow source; exception entry outranks eret, which outranks a branch redirect.
  always_comb begin
    take_redirect = redirect_valid;
    target_pc     = {redirect_pc[31:2], 2'b00};
    misaligned    = redirect_valid && (redirect_pc[1:0] != 2'b00);
`ifdef IFU_EXC_EN
    epc_d = epc_q;
    if (exc_req) begin
      take_redirect = 1'b1;
      target_pc     = EXC_VECTOR;
      misaligned    = 1'b0;
      epc_d         = pc_q;
    end else if (eret) begin
      take_redirect = 1'b1;
      target_pc     = epc_q;
      misaligned    = 1'b0;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    count_d    = count_q;
    addr_err_d = misaligned;

    case (state_q)
      S_REQ: begin
        state_d = S_WAIT;
        if (take_redirect) drop_d = 1'b1;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          // A response that is stale, or made stale this cycle, is dropped and the fetch restarts.
          if (drop_q || take_redirect) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (take_redirect) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          count_d = count_q + 32'd1;
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end else if (take_redirect) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (take_redirect) pc_d = target_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_REQ;
      drop_q     <= 1'b0;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      count_q    <= 32'd0;
      addr_err_q <= 1'b0;
`ifdef IFU_EXC_EN
      epc_q      <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      count_q    <= count_d;
      addr_err_q <= addr_err_d;
`ifdef IFU_EXC_EN
      epc_q      <= epc_d;
`endif
    end
  end

  // The REQ state is the reset state, so the strobe is masked while reset is held.
  assign imem_req    = (state_q == S_REQ) && !reset;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == S_HOLD);
  assign instr_out   = instr_q;
  assign pc_out      = pc_q;
  assign addr_err    = addr_err_q;
  assign fetch_count = count_q;
`ifdef IFU_EXC_EN
  assign epc         = epc_q;
`endif

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// Directed bench for ifu_fetch_unit with a variable-latency memory model and request/handshake scoreboards.
module tb_ifu_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        addr_err;
  logic [31:0] fetch_count;
`ifdef IFU_EXC_EN
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_hs_q[$];

  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;

  ifu_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .addr_err       (addr_err),
    .fetch_count    (fetch_count)
`ifdef IFU_EXC_EN
    , .exc_req      (exc_req),
    .eret           (eret),
    .epc            (epc)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000 ^ {a[7:0], 24'h000000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // Memory: one request in flight, response mem_lat cycles after the accepting edge.
  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    if (imem_req) begin
      mem_addr = imem_addr;
      if (mem_lat <= 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(imem_addr);
        mem_cnt = 0;
      end else begin
        mem_cnt = mem_lat - 1;
      end
    end else if (mem_cnt > 0) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(mem_addr);
      end
    end
  end

  // Scoreboard consumers: every request and every decode handshake must match the next expectation.
  always @(negedge clk) begin
    if (imem_req) begin
      if (exp_addr_q.size() != 0) chk("req_addr", imem_addr, exp_addr_q.pop_front());
      else begin
        n_cmp++;
        n_err++;
        $error("FAIL req_unexpected: observed addr %h, required no request", imem_addr);
      end
    end
    if (instr_valid && instr_ready) begin
      if (exp_hs_q.size() != 0) begin
        logic [63:0] e;
        e = exp_hs_q.pop_front();
        chk("hs_pc", pc_out, e[63:32]);
        chk("hs_instr", instr_out, e[31:0]);
      end else begin
        n_cmp++;
        n_err++;
        $error("FAIL hs_unexpected: observed pc %h, required no handshake", pc_out);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hs(input logic [31:0] a);
    exp_hs_q.push_back({a, mem_word(a)});
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (instr_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    chk(tag, 32'(instr_valid), 32'd1);
  endtask

  task automatic wait_hold_at(input string tag, input logic [31:0] a);
    int k = 0;
    while (!(instr_valid === 1'b1 && pc_out === a) && k < 40) begin
      step();
      k++;
    end
    chk(tag, pc_out, a);
  endtask

  task automatic start_reset(input int lat);
    chk("sb_addr_drained", 32'(exp_addr_q.size()), 32'd0);
    chk("sb_hs_drained", 32'(exp_hs_q.size()), 32'd0);
    exp_addr_q.delete();
    exp_hs_q.delete();
    reset = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
`ifdef IFU_EXC_EN
    exc_req = 1'b0;
    eret = 1'b0;
`endif
    mem_lat = lat;
    repeat (3) step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_pc", pc_out, 32'h0000_3000);
  endtask

  initial begin
    int vcnt;
    // Latency 1, decode always ready: back-to-back sequential fetches.
    start_reset(1);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'h3000 + 32'(4 * i));
    for (int i = 0; i < 3; i++) push_hs(32'h3000 + 32'(4 * i));
    reset = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (instr_valid) vcnt++;
    end
    chk("seq_valid_cycles", 32'(vcnt), 32'd3);
    chk("seq_count", fetch_count, 32'd3);
    instr_ready = 1'b0;
    wait_valid("seq_tail_valid");
    chk("seq_tail_pc", pc_out, 32'h300C);

    // Latency 3, decode stalled: held instruction must stay put.
    start_reset(3);
    exp_addr_q.push_back(32'h3000);
    reset = 1'b0;
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_instr", instr_out, mem_word(32'h3000));
      chk("stall_pc", pc_out, 32'h3000);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_count", fetch_count, 32'd0);
    end
    push_hs(32'h3000);
    exp_addr_q.push_back(32'h3004);
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("stall_count_after", fetch_count, 32'd1);
    wait_valid("stall_next_valid");
    chk("stall_next_pc", pc_out, 32'h3004);

    // Redirect while waiting on memory: stale response discarded.
    start_reset(3);
    exp_addr_q.push_back(32'h3000);
    exp_addr_q.push_back(32'h3100);
    reset = 1'b0;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h3100;
    step();
    redirect_valid = 1'b0;
    chk("wait_redir_pc", pc_out, 32'h3100);
    for (int i = 0; i < 5; i++) begin
      chk("wait_redir_novalid", 32'(instr_valid), 32'd0);
      step();
    end
    wait_valid("wait_redir_valid");
    chk("wait_redir_instr", instr_out, mem_word(32'h3100));

    // Redirect and handshake in the same HOLD cycle.
    start_reset(1);
    instr_ready = 1'b1;
    exp_addr_q.push_back(32'h3000);
    exp_addr_q.push_back(32'h3004);
    exp_addr_q.push_back(32'h3008);
    exp_addr_q.push_back(32'h3040);
    push_hs(32'h3000);
    push_hs(32'h3004);
    push_hs(32'h3008);
    reset = 1'b0;
    wait_hold_at("hold_reach_3008", 32'h3008);
    redirect_valid = 1'b1;
    redirect_pc = 32'h3040;
    step();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    chk("hold_redir_count", fetch_count, 32'd3);
    chk("hold_redir_pc", pc_out, 32'h3040);
    chk("hold_redir_valid", 32'(instr_valid), 32'd0);
    wait_valid("hold_redir_next_valid");
    chk("hold_redir_instr", instr_out, mem_word(32'h3040));

    // Misaligned redirect: one-cycle addr_err, aligned target.
    start_reset(3);
    exp_addr_q.push_back(32'h3000);
    exp_addr_q.push_back(32'h3100);
    reset = 1'b0;
    wait_valid("mis_first_valid");
    redirect_valid = 1'b1;
    redirect_pc = 32'h3102;
    step();
    redirect_valid = 1'b0;
    chk("mis_addr_err_hi", 32'(addr_err), 32'd1);
    chk("mis_valid_drop", 32'(instr_valid), 32'd0);
    chk("mis_pc", pc_out, 32'h3100);
    step();
    chk("mis_addr_err_lo", 32'(addr_err), 32'd0);
    wait_valid("mis_next_valid");
    chk("mis_count", fetch_count, 32'd0);

    // Reset during WAIT; the late response lands while reset is held.
    start_reset(3);
    instr_ready = 1'b1;
    exp_addr_q.push_back(32'h3000);
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("midrst_valid", 32'(instr_valid), 32'd0);
      chk("midrst_req", 32'(imem_req), 32'd0);
    end
    instr_ready = 1'b0;
    exp_addr_q.push_back(32'h3000);
    reset = 1'b0;
    wait_valid("midrst_valid_after");
    chk("midrst_pc_after", pc_out, 32'h3000);
    chk("midrst_instr_after", instr_out, mem_word(32'h3000));

`ifdef IFU_EXC_EN
    // Exception entry from pc 0x3010, then eret back.
    start_reset(1);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) exp_addr_q.push_back(32'h3000 + 32'(4 * i));
    for (int i = 0; i < 4; i++) push_hs(32'h3000 + 32'(4 * i));
    exp_addr_q.push_back(32'h4180);
    reset = 1'b0;
    wait_hold_at("exc_reach_3010", 32'h3010);
    instr_ready = 1'b0;
    exc_req = 1'b1;
    step();
    exc_req = 1'b0;
    chk("exc_epc", epc, 32'h3010);
    chk("exc_pc", pc_out, 32'h4180);
    wait_valid("exc_vec_valid");
    chk("exc_vec_instr", instr_out, mem_word(32'h4180));
    exp_addr_q.push_back(32'h3010);
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk("eret_pc", pc_out, 32'h3010);
    wait_valid("eret_valid");
    chk("eret_instr", instr_out, mem_word(32'h3010));
`endif

    start_reset(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the directed sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
